// File: rtl/replace_policy_pkg.sv
// Shared cache replacement helpers: PLRU tree sizing, index widths, node-child indexing
// and maximal-length LFSR tap masks.
package replace_policy_pkg;

  function automatic int unsigned tree_nodes(input int unsigned num_way);
    return num_way - 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Heap numbering: node k has children 2k+1 (lower ways) and 2k+2 (upper ways).
  function automatic int unsigned node_child(input int unsigned node, input logic upper);
    return 2 * node + (upper ? 32'd2 : 32'd1);
  endfunction

  // Taps for a shift-left Fibonacci LFSR, feedback = ^(state & taps).
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      default: return 32'h0000_0240;
    endcase
  endfunction

endpackage

// File: rtl/bin_to_1h.sv
// Binary to one-hot decoder.
module bin_to_1h #(
  parameter int unsigned Width = 2
) (
  input  logic [Width-1:0]      bin_i,
  output logic [(2**Width)-1:0] oh_o
);

  always_comb begin
    oh_o        = '0;
    oh_o[bin_i] = 1'b1;
  end

endmodule

// File: rtl/lfsr.sv
// Free-running Fibonacci LFSR that advances only when enabled; resets to all-ones.
module lfsr #(
  parameter int unsigned       Width = 4,
  parameter logic [Width-1:0] Taps  = Width'(32'hC)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [Width-1:0] state_o
);

  logic [Width-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) state_d = {state_q[Width-2:0], ^(state_q & Taps)};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= '1;
    else         state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/replace_policy_plru_tree.sv
// Combinational PLRU tree: applies a touch (lowest set bit of touch_way_i) to one tree and
// walks the resulting tree to a one-hot victim.
module replace_policy_plru_tree
  import replace_policy_pkg::*;
#(
  parameter int unsigned NumWay = 4
) (
  input  logic [NumWay-2:0] tree_i,
  input  logic [NumWay-1:0] touch_way_i,
  output logic [NumWay-2:0] tree_o,
  output logic [NumWay-1:0] victim_o
);

  localparam int unsigned Levels = idx_w(NumWay);

  logic              touch_any;
  logic [Levels-1:0] touch_idx;

  assign touch_any = |touch_way_i;

  always_comb begin
    touch_idx = '0;
    for (int i = NumWay - 1; i >= 0; i--) begin
      if (touch_way_i[i]) touch_idx = Levels'(i);
    end
  end

  // Each node on the path is pointed at the sibling half of the touched way.
  always_comb begin
    int unsigned node;
    tree_o = tree_i;
    node   = 0;
    if (touch_any) begin
      for (int l = 0; l < Levels; l++) begin
        tree_o[node] = ~touch_idx[Levels-1-l];
        node         = node_child(node, touch_idx[Levels-1-l]);
      end
    end
  end

  always_comb begin
    int unsigned       node;
    logic [Levels-1:0] vidx;
    node = 0;
    vidx = '0;
    for (int l = 0; l < Levels; l++) begin
      vidx[Levels-1-l] = tree_o[node];
      node             = node_child(node, tree_o[node]);
    end
    victim_o       = '0;
    victim_o[vidx] = 1'b1;
  end

endmodule

// File: rtl/replace_policy.sv
// Per-set victim-way selector. CACHE_PLRU_EN selects a per-set tree PLRU table; otherwise an
// LFSR picks the way. Invalid ways always win; the victim is returned one cycle after sel_req.
module replace_policy
  import replace_policy_pkg::*;
#(
  parameter int unsigned NUM_WAY = 2,
  parameter int unsigned NUM_SET = 256
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       sel_req,
  input  logic [$clog2(NUM_SET)-1:0] sel_index,
  input  logic [NUM_WAY-1:0]         v_ways,
  output logic                       victim_valid,
  output logic [NUM_WAY-1:0]         victim_way,
  input  logic                       touch_en,
  input  logic [$clog2(NUM_SET)-1:0] touch_index,
  input  logic [NUM_WAY-1:0]         touch_way
);

  localparam int unsigned WayIdxW = idx_w(NUM_WAY);

  logic               resp_q;
  logic [NUM_WAY-1:0] hold_q;
  logic [NUM_WAY-1:0] policy_way;
  logic [NUM_WAY-1:0] inv_way;
  logic               any_inv;

  assign any_inv = ~&v_ways;
  // Isolates the lowest clear bit of v_ways.
  assign inv_way = ~v_ways & (v_ways + NUM_WAY'(1));

  always_comb begin
    victim_way = hold_q;
    if (resp_q) victim_way = any_inv ? inv_way : policy_way;
  end

  assign victim_valid = resp_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_q <= 1'b0;
      hold_q <= NUM_WAY'(1);
    end else begin
      resp_q <= sel_req;
      hold_q <= victim_way;
    end
  end

`ifdef CACHE_PLRU_EN
  localparam int unsigned Nodes = tree_nodes(NUM_WAY);

  logic [Nodes-1:0]   tree_q [NUM_SET];
  logic [Nodes-1:0]   tree_upd;
  logic [Nodes-1:0]   unused_sel_tree;
  logic [NUM_WAY-1:0] unused_upd_victim;
  logic [NUM_WAY-1:0] sel_touch;
  logic [NUM_WAY-1:0] sel_plru;
  logic [NUM_WAY-1:0] plru_q;
  logic               fwd;

  // A same-cycle touch on the selected set is applied before the walk.
  assign fwd       = touch_en && (touch_index == sel_index);
  assign sel_touch = fwd ? touch_way : '0;

  replace_policy_plru_tree #(
    .NumWay(NUM_WAY)
  ) u_tree_upd (
    .tree_i     (tree_q[touch_index]),
    .touch_way_i(touch_way),
    .tree_o     (tree_upd),
    .victim_o   (unused_upd_victim)
  );

  replace_policy_plru_tree #(
    .NumWay(NUM_WAY)
  ) u_tree_sel (
    .tree_i     (tree_q[sel_index]),
    .touch_way_i(sel_touch),
    .tree_o     (unused_sel_tree),
    .victim_o   (sel_plru)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < NUM_SET; s++) tree_q[s] <= '0;
      plru_q <= NUM_WAY'(1);
    end else begin
      if (touch_en) tree_q[touch_index] <= tree_upd;
      if (sel_req)  plru_q <= sel_plru;
    end
  end

  assign policy_way = plru_q;
`else
  localparam int unsigned LfsrW = WayIdxW + 2;

  logic [LfsrW-1:0] lfsr_state;
  logic             unused_inputs;

  lfsr #(
    .Width(LfsrW),
    .Taps (LfsrW'(lfsr_taps(LfsrW)))
  ) u_lfsr (
    .clk_i  (clk),
    .rst_ni (resetn),
    .en_i   (resp_q & ~any_inv),
    .state_o(lfsr_state)
  );

  bin_to_1h #(
    .Width(WayIdxW)
  ) u_dec (
    .bin_i(lfsr_state[WayIdxW-1:0]),
    .oh_o (policy_way)
  );

  assign unused_inputs = ^{sel_index, touch_en, touch_index, touch_way,
                           lfsr_state[LfsrW-1:WayIdxW]};
`endif

endmodule

// File: tb/tb_replace_policy.sv
// Bench for replace_policy (NUM_WAY=4, NUM_SET=16); follows CACHE_PLRU_EN like the design.
module tb_replace_policy;

  localparam int NW = 4;
  localparam int NS = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       sel_req = 1'b0;
  logic [3:0] sel_index = '0;
  logic [3:0] v_ways = 4'hF;
  logic       victim_valid;
  logic [3:0] victim_way;
  logic       touch_en = 1'b0;
  logic [3:0] touch_index = '0;
  logic [3:0] touch_way = '0;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  replace_policy #(
    .NUM_WAY(NW),
    .NUM_SET(NS)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .sel_req     (sel_req),
    .sel_index   (sel_index),
    .v_ways      (v_ways),
    .victim_valid(victim_valid),
    .victim_way  (victim_way),
    .touch_en    (touch_en),
    .touch_index (touch_index),
    .touch_way   (touch_way)
  );

  // Reference model state
  bit         m_pend;
  int         m_pend_way;
  logic [3:0] m_hold;
  int         m_lfsr;
  bit         m_tree[NS][NW-1];

  function automatic void check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [3:0] lowest_zero(input logic [3:0] v);
    for (int i = 0; i < NW; i++) if (!v[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  function automatic int lowest_one(input logic [3:0] v);
    for (int i = 0; i < NW; i++) if (v[i]) return i;
    return 0;
  endfunction

  // x^4 + x^3 + 1, shifting left, new bit into bit 0
  function automatic int lfsr_step(input int s);
    return ((s << 1) | (((s >> 3) ^ (s >> 2)) & 1)) & 15;
  endfunction

  // Halve the way range at each node; a touched node points to the other half.
  function automatic void m_touch(input int set, input int way);
    int node = 0;
    int lo = 0;
    int hi = NW;
    while (hi - lo > 1) begin
      int mid;
      mid = (lo + hi) / 2;
      if (way < mid) begin
        m_tree[set][node] = 1'b1;
        node = 2 * node + 1;
        hi = mid;
      end else begin
        m_tree[set][node] = 1'b0;
        node = 2 * node + 2;
        lo = mid;
      end
    end
  endfunction

  function automatic int m_pick(input int set);
    int node = 0;
    int lo = 0;
    int hi = NW;
    while (hi - lo > 1) begin
      int mid;
      mid = (lo + hi) / 2;
      if (m_tree[set][node]) begin
        lo = mid;
        node = 2 * node + 2;
      end else begin
        hi = mid;
        node = 2 * node + 1;
      end
    end
    return lo;
  endfunction

  always @(negedge clk) begin
    logic [3:0] exp_way;
    if (!resetn) begin
      m_pend = 1'b0;
      m_hold = 4'b0001;
      m_lfsr = 15;
      foreach (m_tree[i, j]) m_tree[i][j] = 1'b0;
      check("reset_valid", {3'b000, victim_valid}, 4'b0000);
      check("reset_way", victim_way, 4'b0001);
    end else begin
      if (m_pend) begin
        if (v_ways != 4'hF) begin
          exp_way = lowest_zero(v_ways);
        end else begin
`ifdef CACHE_PLRU_EN
          exp_way = 4'(1 << m_pend_way);
`else
          exp_way = 4'(1 << (m_lfsr % 4));
          m_lfsr  = lfsr_step(m_lfsr);
`endif
        end
        m_hold = exp_way;
      end else begin
        exp_way = m_hold;
      end
      check("model_valid", {3'b000, victim_valid}, {3'b000, m_pend});
      check("model_way", victim_way, exp_way);
`ifdef CACHE_PLRU_EN
      if (touch_en && touch_way != 4'b0000) m_touch(int'(touch_index), lowest_one(touch_way));
      if (sel_req) m_pend_way = m_pick(int'(sel_index));
`endif
      m_pend = sel_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic touch(input logic [3:0] idx, input logic [3:0] way);
    touch_en = 1'b1;
    touch_index = idx;
    touch_way = way;
    step();
    touch_en = 1'b0;
  endtask

  // Request in this cycle, present v in the response cycle and check a literal victim.
  task automatic select(input logic [3:0] idx, input logic [3:0] v, input string name,
                        input logic [3:0] exp);
    sel_req = 1'b1;
    sel_index = idx;
    step();
    sel_req = 1'b0;
    touch_en = 1'b0;
    v_ways = v;
    @(negedge clk);
    check(name, victim_way, exp);
    check({name, "_vld"}, {3'b000, victim_valid}, 4'b0001);
    step();
    v_ways = 4'hF;
  endtask

  initial begin
    logic [3:0] seen;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    step();

`ifdef CACHE_PLRU_EN
    select(4'd5, 4'hF, "rst_sel", 4'b0001);
    touch(4'd5, 4'b0001);
    select(4'd5, 4'hF, "after_t0", 4'b0100);
    touch(4'd5, 4'b0100);
    select(4'd5, 4'hF, "after_t2", 4'b0010);
    select(4'd3, 4'b1011, "inv2", 4'b0100);
    select(4'd3, 4'b0000, "inv0", 4'b0001);
    touch_en = 1'b1; touch_index = 4'd7; touch_way = 4'b0001;
    select(4'd7, 4'hF, "fwd", 4'b0100);
    touch_en = 1'b1; touch_index = 4'd8; touch_way = 4'b0001;
    select(4'd10, 4'hF, "no_fwd", 4'b0001);
    touch(4'd2, 4'b0001);
    touch(4'd2, 4'b0010);
    touch(4'd2, 4'b0100);
    touch(4'd2, 4'b1000);
    select(4'd9, 4'hF, "iso", 4'b0001);
    touch(4'd11, 4'b0011);
    touch(4'd11, 4'b0100);
    select(4'd11, 4'hF, "multihot", 4'b0010);
    touch(4'd12, 4'b0000);
    select(4'd12, 4'hF, "zero_touch", 4'b0001);
`else
    select(4'd5, 4'hF, "rst_sel", 4'b1000);
    select(4'd5, 4'hF, "lfsr1", 4'b0100);
    select(4'd3, 4'b1011, "inv2", 4'b0100);
    select(4'd3, 4'b0000, "inv0", 4'b0001);
    touch(4'd5, 4'b0001);
    select(4'd5, 4'hF, "frozen", 4'b0001);
    select(4'd1, 4'hF, "lfsr3", 4'b0001);
    select(4'd1, 4'hF, "lfsr4", 4'b0010);

    seen = 4'b0000;
    sel_req = 1'b1;
    v_ways = 4'hF;
    for (int c = 0; c < 64; c++) begin
      step();
      @(negedge clk);
      seen |= victim_way;
      check("onehot", {3'b000, 1'($onehot(victim_way))}, 4'b0001);
    end
    sel_req = 1'b0;
    step();
    check("all_ways", seen, 4'b1111);

    sel_req = 1'b1;
    v_ways = 4'b1101;
    for (int c = 0; c < 16; c++) begin
      step();
      @(negedge clk);
      check("one_invalid", victim_way, 4'b0010);
    end
    sel_req = 1'b0;
    v_ways = 4'hF;
    step();
`endif

    for (int c = 0; c < 200; c++) begin
      sel_req = ($urandom_range(0, 3) != 0);
      sel_index = 4'($urandom_range(0, 15));
      touch_en = 1'($urandom_range(0, 1));
      touch_index = ($urandom_range(0, 1) != 0) ? sel_index : 4'($urandom_range(0, 15));
      touch_way = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      v_ways = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      step();
    end
    sel_req = 1'b0;
    touch_en = 1'b0;
    v_ways = 4'hF;
    step();

    sel_req = 1'b1;
    sel_index = 4'd5;
    step();
    sel_req = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    check("rst_drop", {3'b000, victim_valid}, 4'b0000);
    step();
    resetn = 1'b1;
    step();
`ifdef CACHE_PLRU_EN
    select(4'd5, 4'hF, "post_rst", 4'b0001);
`else
    select(4'd5, 4'hF, "post_rst", 4'b1000);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
